// File: rtl/regfile_bypass_if.sv
// regfile_bypass_if
//   Bundles the register-file access signals between the pipeline (master)
//   and the register file (slave).
//
// Flow control: there is no valid/ready handshake. A write happens at any
// posedge where RegWrite=1. In the registered read mode, ren=1 at a posedge
// captures a new read; ren=0 holds the previous read data (stall). In the
// combinational mode, ren is ignored. The debug port is untimed and
// combinational.
//
//   RegWrite, waddr, wbe, wdat : write port (writeback stage)
//   raddr_a/b, ren             : read addresses and read-stage advance
//   rdat_a/b                   : read data (optionally bypassed)
//   dbg_addr, dbg_dat          : debug read, storage contents only
interface regfile_bypass_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  RegWrite;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W/8-1:0]   wbe;
  logic [DATA_W-1:0]     wdat;
  logic [ADDR_W-1:0]     raddr_a;
  logic [ADDR_W-1:0]     raddr_b;
  logic                  ren;
  logic [DATA_W-1:0]     rdat_a;
  logic [DATA_W-1:0]     rdat_b;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_dat;

  modport master (
    output RegWrite, waddr, wbe, wdat, raddr_a, raddr_b, ren, dbg_addr,
    input  rdat_a, rdat_b, dbg_dat
  );

  modport slave (
    input  RegWrite, waddr, wbe, wdat, raddr_a, raddr_b, ren, dbg_addr,
    output rdat_a, rdat_b, dbg_dat
  );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass
//   General-purpose register file with two read ports, one byte-lane-masked
//   write port and a debug read port. Same-cycle writes are forwarded to the
//   read ports (never to the debug port). Entry 0 can be hardwired to zero.
//   The read ports are either combinational (REG_READ=0) or registered with a
//   stall input (REG_READ=1).
//
// Ports:
//   clk : clock, all state updates on posedge
//   rst : asynchronous active-high reset, clears storage and read registers
//   rf  : regfile_bypass_if.slave (write port, read ports, debug port)
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int REG_READ = 0
) (
  input logic              clk,
  input logic              rst,
  regfile_bypass_if.slave  rf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NLANE = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              zero_wr;
  logic              wr_eff;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] byp_a;
  logic [DATA_W-1:0] byp_b;

  // A write to the hardwired zero entry is dropped entirely. While rst is
  // held no write is effective, so nothing can be forwarded to the readers.
  assign zero_wr = (ZERO_REG != 0) && (rf.waddr == '0);
  assign wr_eff  = !rst && rf.RegWrite && (|rf.wbe) && !zero_wr;

  // The new content of the target entry: enabled lanes from wdat, the rest
  // kept. The same value is stored and forwarded.
  always_comb begin
    wr_merged = mem[rf.waddr];
    for (int i = 0; i < NLANE; i++) begin
      if (rf.wbe[i]) begin
        wr_merged[8*i +: 8] = rf.wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_eff) begin
      mem[rf.waddr] <= wr_merged;
    end
  end

  // Forwarded read values. Entry 0 is never written when ZERO_REG=1, so it
  // already reads 0; the explicit override keeps that independent of the
  // write gating.
  always_comb begin
    byp_a = mem[rf.raddr_a];
    if (wr_eff && (rf.waddr == rf.raddr_a)) begin
      byp_a = wr_merged;
    end
    if ((ZERO_REG != 0) && (rf.raddr_a == '0)) begin
      byp_a = '0;
    end
  end

  always_comb begin
    byp_b = mem[rf.raddr_b];
    if (wr_eff && (rf.waddr == rf.raddr_b)) begin
      byp_b = wr_merged;
    end
    if ((ZERO_REG != 0) && (rf.raddr_b == '0)) begin
      byp_b = '0;
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] q_b;

    // Captured data is frozen: a later write to the same entry does not
    // touch it until the next capture.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_a <= '0;
        q_b <= '0;
      end else if (rf.ren) begin
        q_a <= byp_a;
        q_b <= byp_b;
      end
    end

    assign rf.rdat_a = q_a;
    assign rf.rdat_b = q_b;
  end else begin : g_comb_read
    assign rf.rdat_a = byp_a;
    assign rf.rdat_b = byp_b;
  end

  // Debug view of storage only; no forwarding.
  assign rf.dbg_dat = mem[rf.dbg_addr];

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass
//   Drives two register files with identical stimulus:
//     dut_c : ZERO_REG=1, REG_READ=0 (combinational reads)
//     dut_r : ZERO_REG=0, REG_READ=1 (registered reads)
//   A behavioural model (array per instance plus a capture queue for the
//   registered ports) supplies all expected values.
module tb_regfile_bypass;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- stimulus variables ----------------
  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_wa = '0;
  logic [3:0]    cur_be = '0;
  logic [DW-1:0] cur_wd = '0;
  logic [AW-1:0] cur_ra = '0;
  logic [AW-1:0] cur_rb = '0;
  logic          cur_rn = 1'b0;
  logic [AW-1:0] cur_da = '0;

  regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) if_c ();
  regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) if_r ();

  assign if_c.RegWrite = cur_we;
  assign if_c.waddr    = cur_wa;
  assign if_c.wbe      = cur_be;
  assign if_c.wdat     = cur_wd;
  assign if_c.raddr_a  = cur_ra;
  assign if_c.raddr_b  = cur_rb;
  assign if_c.ren      = cur_rn;
  assign if_c.dbg_addr = cur_da;

  assign if_r.RegWrite = cur_we;
  assign if_r.waddr    = cur_wa;
  assign if_r.wbe      = cur_be;
  assign if_r.wdat     = cur_wd;
  assign if_r.raddr_a  = cur_ra;
  assign if_r.raddr_b  = cur_rb;
  assign if_r.ren      = cur_rn;
  assign if_r.dbg_addr = cur_da;

  regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .REG_READ(0)) dut_c (
    .clk (clk),
    .rst (rst),
    .rf  (if_c)
  );

  regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .REG_READ(1)) dut_r (
    .clk (clk),
    .rst (rst),
    .rf  (if_r)
  );

  // ---------------- reference model ----------------
  // m[0] models dut_c (zero register), m[1] models dut_r.
  logic [DW-1:0] m [2][32];
  logic [DW-1:0] held_a = '0;
  logic [DW-1:0] held_b = '0;
  logic [2*DW-1:0] exp_q[$];

  // Value a read port should see this cycle for instance d: stored word,
  // overlaid by any same-cycle write to that address.
  function automatic logic [DW-1:0] model_port(int d, logic [AW-1:0] ra);
    logic [DW-1:0] v;
    bit zr;
    zr = (d == 0);
    if (zr && ra == 0) return '0;
    v = m[d][ra];
    if (cur_we && cur_be != 0 && !(zr && cur_wa == 0) && cur_wa == ra) begin
      for (int i = 0; i < 4; i++)
        if (cur_be[i]) v[8*i +: 8] = cur_wd[8*i +: 8];
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) m[d][a] = '0;
    held_a = '0;
    held_b = '0;
    exp_q.delete();
  endtask

  // One clock edge: update the model from the inputs present at the edge,
  // then leave 1 time unit so DUT outputs have settled.
  task automatic tick();
    logic [DW-1:0] nv [2];
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (cur_rn) exp_q.push_back({model_port(1, cur_ra), model_port(1, cur_rb)});
      for (int d = 0; d < 2; d++) nv[d] = model_port(d, cur_wa);
      for (int d = 0; d < 2; d++)
        if (cur_we && !(d == 0 && cur_wa == 0)) m[d][cur_wa] = nv[d];
    end
    #1;
    if (exp_q.size() > 0) {held_a, held_b} = exp_q.pop_front();
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [3:0] be,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input logic rn, input logic [AW-1:0] da);
    cur_we = we; cur_wa = wa; cur_be = be; cur_wd = wd;
    cur_ra = ra; cur_rb = rb; cur_rn = rn; cur_da = da;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd3, 4'hF, 32'hCAFEF00D, 5'd3, 5'd3, 1'b1, 5'd3);
    tick();
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (if_c.rdat_a !== 32'h0) begin failures++; $display("FAIL reset_c_rdat_a: got %h expected %h", if_c.rdat_a, 32'h0); end
    checks++;
    if (if_c.rdat_b !== 32'h0) begin failures++; $display("FAIL reset_c_rdat_b: got %h expected %h", if_c.rdat_b, 32'h0); end
    checks++;
    if (if_r.rdat_a !== 32'h0) begin failures++; $display("FAIL reset_r_rdat_a: got %h expected %h", if_r.rdat_a, 32'h0); end
    checks++;
    if (if_r.dbg_dat !== 32'h0) begin failures++; $display("FAIL reset_r_dbg: got %h expected %h", if_r.dbg_dat, 32'h0); end
    rst = 1'b0;
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd3);
    tick();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 5'd1, 5'd1, 1'b0, 5'd5);
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd5);
    #1;
    checks++;
    if (if_c.rdat_a !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset_r5: got %h expected %h", if_c.rdat_a, 32'hDEADBEEF); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (if_c.rdat_a !== 32'h0) begin failures++; $display("FAIL async_reset_c_rdat_a: got %h expected %h", if_c.rdat_a, 32'h0); end
    checks++;
    if (if_r.dbg_dat !== 32'h0) begin failures++; $display("FAIL async_reset_r_dbg: got %h expected %h", if_r.dbg_dat, 32'h0); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5, 1'b1, 5'd5);
    tick();
    checks++;
    if (if_c.rdat_a !== 32'h0) begin failures++; $display("FAIL post_reset_r5_c: got %h expected %h", if_c.rdat_a, 32'h0); end
    checks++;
    if (if_r.rdat_a !== 32'h0) begin failures++; $display("FAIL post_reset_r5_r: got %h expected %h", if_r.rdat_a, 32'h0); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1'b1, 5'd7, 4'hF, 32'h12345678, 5'd1, 5'd2, 1'b0, 5'd0);
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd7);
    #1;
    checks++;
    if (if_c.rdat_a !== 32'h12345678) begin failures++; $display("FAIL wr_rd_a: got %h expected %h", if_c.rdat_a, 32'h12345678); end
    checks++;
    if (if_c.rdat_b !== 32'h12345678) begin failures++; $display("FAIL wr_rd_b: got %h expected %h", if_c.rdat_b, 32'h12345678); end
    checks++;
    if (if_r.dbg_dat !== 32'h12345678) begin failures++; $display("FAIL wr_rd_r_dbg: got %h expected %h", if_r.dbg_dat, 32'h12345678); end
  endtask

  task automatic test_byte_lanes();
    @(negedge clk);
    drive(1'b1, 5'd7, 4'b0101, 32'hAABBCCDD, 5'd7, 5'd7, 1'b1, 5'd7);
    #1;
    checks++;
    if (if_c.rdat_a !== 32'h12BB56DD) begin failures++; $display("FAIL lanes_bypass_a: got %h expected %h", if_c.rdat_a, 32'h12BB56DD); end
    checks++;
    if (if_c.rdat_b !== 32'h12BB56DD) begin failures++; $display("FAIL lanes_bypass_b: got %h expected %h", if_c.rdat_b, 32'h12BB56DD); end
    checks++;
    if (if_c.dbg_dat !== 32'h12345678) begin failures++; $display("FAIL lanes_dbg_no_bypass: got %h expected %h", if_c.dbg_dat, 32'h12345678); end
    tick();
    checks++;
    if (if_r.rdat_a !== 32'h12BB56DD) begin failures++; $display("FAIL lanes_r_capture: got %h expected %h", if_r.rdat_a, 32'h12BB56DD); end
    @(negedge clk);
    drive(1'b1, 5'd7, 4'b0000, 32'hFFFFFFFF, 5'd7, 5'd7, 1'b0, 5'd7);
    #1;
    checks++;
    if (if_c.dbg_dat !== 32'h12BB56DD) begin failures++; $display("FAIL lanes_stored: got %h expected %h", if_c.dbg_dat, 32'h12BB56DD); end
    checks++;
    if (if_c.rdat_a !== 32'h12BB56DD) begin failures++; $display("FAIL lanes_wbe0_no_bypass: got %h expected %h", if_c.rdat_a, 32'h12BB56DD); end
    tick();
    checks++;
    if (if_c.dbg_dat !== 32'h12BB56DD) begin failures++; $display("FAIL lanes_wbe0_unchanged: got %h expected %h", if_c.dbg_dat, 32'h12BB56DD); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
    #1;
    checks++;
    if (if_c.rdat_a !== 32'h0) begin failures++; $display("FAIL zero_same_a: got %h expected %h", if_c.rdat_a, 32'h0); end
    checks++;
    if (if_c.rdat_b !== 32'h0) begin failures++; $display("FAIL zero_same_b: got %h expected %h", if_c.rdat_b, 32'h0); end
    tick();
    checks++;
    if (if_c.dbg_dat !== 32'h0) begin failures++; $display("FAIL zero_dbg_c: got %h expected %h", if_c.dbg_dat, 32'h0); end
    checks++;
    if (if_c.rdat_a !== 32'h0) begin failures++; $display("FAIL zero_after_a: got %h expected %h", if_c.rdat_a, 32'h0); end
    checks++;
    if (if_r.rdat_a !== 32'hFFFFFFFF) begin failures++; $display("FAIL nozero_r_a: got %h expected %h", if_r.rdat_a, 32'hFFFFFFFF); end
    checks++;
    if (if_r.rdat_b !== 32'hFFFFFFFF) begin failures++; $display("FAIL nozero_r_b: got %h expected %h", if_r.rdat_b, 32'hFFFFFFFF); end
    checks++;
    if (if_r.dbg_dat !== 32'hFFFFFFFF) begin failures++; $display("FAIL nozero_r_dbg: got %h expected %h", if_r.dbg_dat, 32'hFFFFFFFF); end
  endtask

  task automatic test_registered();
    @(negedge clk);
    drive(1'b1, 5'd3, 4'hF, 32'h11, 5'd1, 5'd1, 1'b0, 5'd3);
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3);
    tick();
    checks++;
    if (if_r.rdat_a !== 32'h11) begin failures++; $display("FAIL regread_n: got %h expected %h", if_r.rdat_a, 32'h11); end
    @(negedge clk);
    drive(1'b1, 5'd3, 4'hF, 32'h22, 5'd3, 5'd3, 1'b1, 5'd3);
    tick();
    checks++;
    if (if_r.rdat_a !== 32'h22) begin failures++; $display("FAIL regread_n1: got %h expected %h", if_r.rdat_a, 32'h22); end
    @(negedge clk);
    drive(1'b1, 5'd3, 4'hF, 32'h33, 5'd3, 5'd3, 1'b0, 5'd3);
    tick();
    checks++;
    if (if_r.rdat_a !== 32'h22) begin failures++; $display("FAIL regread_stall: got %h expected %h", if_r.rdat_a, 32'h22); end
    checks++;
    if (if_r.dbg_dat !== 32'h33) begin failures++; $display("FAIL regread_dbg: got %h expected %h", if_r.dbg_dat, 32'h33); end
  endtask

  task automatic test_random_sweep();
    logic [DW-1:0] e;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)),
            4'($urandom_range(0, 15)),
            $urandom(),
            ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)),
            ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0,
            AW'($urandom_range(0, 31)));
      #1;
      e = model_port(0, cur_ra);
      checks++;
      if (if_c.rdat_a !== e) begin failures++; $display("FAIL rand_c_rdat_a[%0d]: got %h expected %h", n, if_c.rdat_a, e); end
      e = model_port(0, cur_rb);
      checks++;
      if (if_c.rdat_b !== e) begin failures++; $display("FAIL rand_c_rdat_b[%0d]: got %h expected %h", n, if_c.rdat_b, e); end
      checks++;
      if (if_c.dbg_dat !== m[0][cur_da]) begin failures++; $display("FAIL rand_c_dbg[%0d]: got %h expected %h", n, if_c.dbg_dat, m[0][cur_da]); end
      checks++;
      if (if_r.dbg_dat !== m[1][cur_da]) begin failures++; $display("FAIL rand_r_dbg[%0d]: got %h expected %h", n, if_r.dbg_dat, m[1][cur_da]); end
      checks++;
      if (if_r.rdat_a !== held_a) begin failures++; $display("FAIL rand_r_rdat_a[%0d]: got %h expected %h", n, if_r.rdat_a, held_a); end
      checks++;
      if (if_r.rdat_b !== held_b) begin failures++; $display("FAIL rand_r_rdat_b[%0d]: got %h expected %h", n, if_r.rdat_b, held_b); end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_clear();
    test_reset();
    test_async_reset();
    test_write_read();
    test_byte_lanes();
    test_zero_reg();
    test_registered();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
